addsub_seq: RTL and testbench
=============================

ADDSUB_SEQ -- requirements
Module: addsub_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK; NCHUNK = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operands/op valid.
REQ-006 SHALL have port in_ready  output  1  block can accept an operation.
REQ-007 SHALL have port A  input  WIDTH  first operand, two's complement.
REQ-008 SHALL have port B  input  WIDTH  second operand, two's complement.
REQ-009 SHALL have port sub  input  1  0 = A+B, 1 = A-B.
REQ-010 SHALL have port out_valid  output  1  result and flags valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port Sum  output  WIDTH  result.
REQ-013 SHALL have ports Ovfl, Zero, Neg  output  1 each  signed overflow, result==0, result MSB.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-015 IDLE: on in_valid=1, SHALL register A, effective B (B if sub=0, ~B if sub=1), sub; set carry=sub, chunk counter=0; go BUSY.
REQ-016 BUSY: each cycle SHALL add chunk[cnt] of A, effective B and carry, write that chunk of the internal result register, update carry, increment cnt.
REQ-017 BUSY SHALL go DONE in the cycle cnt==NCHUNK-1; out_valid SHALL rise exactly NCHUNK+1 rising edges after the accepting edge (first output cycle = edge NCHUNK+1).
REQ-018 Ovfl SHALL be 1 when sign of A equals sign of effective B and result sign differs; Zero and Neg SHALL reflect final Sum (after REQ-025 if enabled).
REQ-019 Sum and flags SHALL update only on the BUSY-to-DONE transition and remain stable throughout DONE.
REQ-020 DONE: SHALL hold until out_valid & out_ready, then go IDLE next edge; no new operation accepted in the same cycle.
REQ-021 in_valid outside IDLE SHALL be ignored; operand inputs SHALL not affect an operation after acceptance.
REQ-022 Arithmetic SHALL wrap modulo 2^WIDTH (unless REQ-025); final carry-out is discarded.

Reset
REQ-023 rst=1 at a rising edge SHALL force IDLE, cnt=0, carry=0, Sum=0, Ovfl=Zero=Neg=0, out_valid=0, in_ready=1 regardless of state, including mid-BUSY or DONE; in-flight operation is dropped.

Configuration
REQ-024 Macro ADDSUB_SAT_EN SHALL select saturation mode at compile time.
REQ-025 With ADDSUB_SAT_EN defined: on Ovfl=1, Sum SHALL be 0111..1 if A non-negative, 1000..0 if A negative; Ovfl still reported as 1. Undefined: wrap per REQ-022.

Structure
REQ-026 Package addsub_pkg SHALL hold the FSM state enum (IDLE, BUSY, DONE) and saturation constants derived from WIDTH.
REQ-027 SHALL instantiate one sub-module chunk_adder (parameter CHUNK; inputs a, b, cin; outputs s, cout), combinational ripple carry.

Verification (WIDTH=16, CHUNK=4)
REQ-028 A=0x1234, B=0x0FED, sub=0 -> Sum=0x2221, Ovfl=0, Zero=0, Neg=0, out_valid 5 edges after accept.
REQ-029 A=0x7FFF, B=0x0001, sub=0 -> Ovfl=1; wrap: Sum=0x8000, Neg=1; ADDSUB_SAT_EN: Sum=0x7FFF, Neg=0.
REQ-030 A=0x8000, B=0x0001, sub=1 -> Ovfl=1; wrap: Sum=0x7FFF, Neg=0; ADDSUB_SAT_EN: Sum=0x8000, Neg=1.
REQ-031 A=0x0005, B=0x0005, sub=1 -> Sum=0x0000, Zero=1, Ovfl=0, Neg=0.
REQ-032 out_ready=0 for 3 cycles in DONE with in_valid=1 held -> Sum/flags stable, in_ready=0, no second accept; out_ready=1 -> IDLE next edge.
REQ-033 rst=1 on second BUSY cycle -> next cycle IDLE, out_valid=0, Sum=0, in_ready=1; following op A=0x0001, B=0x0002, sub=0 -> Sum=0x0003.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared definitions for the sequential chunked adder/subtractor.
// Holds the FSM state encoding and the default geometry.
// Also holds helpers that derive the saturation limits from an operand width.
package addsub_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_CHUNK = 4;
   localparam int MAX_WIDTH = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Largest positive two's complement value of the given width: 0111..1
   function automatic logic [MAX_WIDTH-1:0] sat_pos(input int width);
      return {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width + 1);
   endfunction

   // Most negative two's complement value of the given width: 1000..0
   function automatic logic [MAX_WIDTH-1:0] sat_neg(input int width);
      return {{(MAX_WIDTH-1){1'b0}}, 1'b1} << (width - 1);
   endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational ripple-carry adder for one CHUNK-bit slice.
// Ports: a, b (CHUNK-bit addends), cin (carry in), s (CHUNK-bit sum), cout (carry out).
// No latency, no flow control.
module chunk_adder #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout
);

   logic c;

   always_comb begin
      c = cin;
      s = '0;
      for (int i = 0; i < CHUNK; i++) begin
         s[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/addsub_seq.sv
// Sequential two's complement add/subtract, CHUNK bits per cycle, with Ovfl/Zero/Neg flags.
// Latency: out_valid rises NCHUNK+1 edges after the accepting edge; one op in flight at a time.
// Backpressure: result held stable in DONE until out_ready; in_ready only in IDLE.
// Ports: clk, rst (sync, active-high), in_valid/in_ready, A, B, sub (0 add, 1 subtract),
//        out_valid/out_ready, Sum, Ovfl, Zero, Neg.
// Build option: define ADDSUB_SAT_EN to saturate Sum on signed overflow instead of wrapping.
module addsub_seq
   import addsub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Ovfl,
   output logic             Zero,
   output logic             Neg
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

`ifdef ADDSUB_SAT_EN
   localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_pos(WIDTH));
   localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_neg(WIDTH));
`endif

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic             carry_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;      // effective B: already inverted for subtraction
   logic [WIDTH-1:0] res_q;
   logic [WIDTH-1:0] sum_q;
   logic             ovfl_q, zero_q, neg_q;
   logic             in_ready_q, out_valid_q;

   logic [CHUNK-1:0] s_w;
   logic             cout_w;
   logic [WIDTH-1:0] res_d;
   logic [WIDTH-1:0] sum_d;
   logic             ovfl_d;

   chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .a    (a_q[cnt_q*CHUNK +: CHUNK]),
      .b    (b_q[cnt_q*CHUNK +: CHUNK]),
      .cin  (carry_q),
      .s    (s_w),
      .cout (cout_w)
   );

   // res_d is the result register with the current chunk merged in; on the
   // last BUSY cycle it is the complete result, so the flags are taken from it.
   always_comb begin
      res_d = res_q;
      res_d[cnt_q*CHUNK +: CHUNK] = s_w;
      ovfl_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
      sum_d  = res_d;
`ifdef ADDSUB_SAT_EN
      if (ovfl_d) begin
         sum_d = a_q[WIDTH-1] ? SAT_NEG : SAT_POS;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         sum_q       <= '0;
         ovfl_q      <= 1'b0;
         zero_q      <= 1'b0;
         neg_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q        <= A;
                  b_q        <= sub ? ~B : B;
                  carry_q    <= sub;   // +1 completes the two's complement of B
                  cnt_q      <= '0;
                  res_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= BUSY;
               end
            end
            BUSY: begin
               res_q   <= res_d;
               carry_q <= cout_w;
               if (cnt_q == CW'(NCHUNK - 1)) begin
                  // Final carry-out is discarded: arithmetic wraps mod 2^WIDTH.
                  sum_q   <= sum_d;
                  ovfl_q  <= ovfl_d;
                  zero_q  <= (sum_d == '0);
                  neg_q   <= sum_d[WIDTH-1];
                  cnt_q   <= '0;
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               // out_valid is presented one edge after entering DONE.
               if (!out_valid_q) begin
                  out_valid_q <= 1'b1;
               end else if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign Sum       = sum_q;
   assign Ovfl      = ovfl_q;
   assign Zero      = zero_q;
   assign Neg       = neg_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Testbench for addsub_seq (WIDTH=16, CHUNK=4): directed corner cases, reset
// mid-operation, backpressure in DONE, and randomized operations against an
// integer-arithmetic reference model.
module tb_addsub_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] A, B;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] Sum;
   logic        Ovfl, Zero, Neg;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   addsub_seq #(.WIDTH(16), .CHUNK(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Sum       (Sum),
      .Ovfl      (Ovfl),
      .Zero      (Zero),
      .Neg       (Neg)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: signed integer arithmetic, overflow = result outside 16-bit signed range.
   function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic s,
                                 output logic [15:0] sum, output logic ov);
      int sa, sb, full;
      sa   = int'($signed(a));
      sb   = int'($signed(b));
      full = s ? (sa - sb) : (sa + sb);
      ov   = (full > 32767) || (full < -32768);
      sum  = 16'(full);
`ifdef ADDSUB_SAT_EN
      if (ov) sum = (sa < 0) ? 16'h8000 : 16'h7FFF;
`endif
   endfunction

   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input int hold, input string tag);
      logic [15:0] es;
      logic        eo;
      int          edges;
      model(a, b, s, es, eo);
      @(negedge clk);
      chk({tag, ".in_ready_idle"}, in_ready, 1);
      A = a; B = b; sub = s; in_valid = 1'b1;
      @(posedge clk); #1;
      // Scramble operands after acceptance; in_valid stays high and must be ignored.
      A = 16'($urandom); B = 16'($urandom); sub = 1'($urandom);
      edges = 0;
      while (!out_valid && edges < 20) begin
         @(posedge clk); #1;
         edges++;
      end
      chk({tag, ".latency"}, edges, 5);
      chk({tag, ".sum"},  Sum,  es);
      chk({tag, ".ovfl"}, Ovfl, eo);
      chk({tag, ".zero"}, Zero, (es == 16'h0));
      chk({tag, ".neg"},  Neg,  es[15]);
      chk({tag, ".in_ready_done"}, in_ready, 0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({tag, ".hold_sum"},  {Ovfl, Zero, Neg, Sum}, {eo, (es == 16'h0), es[15], es});
         chk({tag, ".hold_vld"},  out_valid, 1);
         chk({tag, ".hold_rdy"},  in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk({tag, ".exit_vld"}, out_valid, 0);
      chk({tag, ".exit_rdy"}, in_ready, 1);
   endtask

   initial begin
      logic [15:0] ra, rb;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      A = '0; B = '0; sub = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset.in_ready",  in_ready, 1);
      chk("reset.out_valid", out_valid, 0);
      chk("reset.sum",       Sum, 0);
      chk("reset.flags",     {Ovfl, Zero, Neg}, 0);
      rst = 1'b0;

      run_op(16'h1234, 16'h0FED, 1'b0, 0, "add_basic");
      run_op(16'h7FFF, 16'h0001, 1'b0, 1, "add_ovfl");
      run_op(16'h8000, 16'h0001, 1'b1, 0, "sub_ovfl");
      run_op(16'h0005, 16'h0005, 1'b1, 0, "sub_zero");
      run_op(16'hFFFF, 16'h0001, 1'b0, 3, "backpressure");
      run_op(16'h8000, 16'h8000, 1'b0, 0, "neg_neg_ovfl");
      run_op(16'h0000, 16'h8000, 1'b1, 0, "sub_min");

      // Reset during the second BUSY cycle drops the operation.
      @(negedge clk);
      A = 16'h4321; B = 16'h1111; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst.out_valid", out_valid, 0);
      chk("midrst.sum",       Sum, 0);
      chk("midrst.in_ready",  in_ready, 1);
      chk("midrst.flags",     {Ovfl, Zero, Neg}, 0);
      run_op(16'h0001, 16'h0002, 1'b0, 0, "after_rst");

      for (int i = 0; i < 25; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         run_op(ra, rb, 1'($urandom), $urandom_range(0, 3), "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
